feature_extractor_win: RTL and testbench
========================================

Name: feature_extractor_win

Overview:
- Parametrised successor to the pass-through feature extractor in the safety monitoring datapath. It sits between the sensor front-end and the safety classifier.
- Accepts qualified accel/brake samples. Produces a windowed average of accel magnitude, a running accel peak, and a saturated brake rate (sample-to-sample delta).
- data_valid is qualified by window warm-up, so the classifier never acts on partial windows.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (16): sample and feature width.
- WIN_LOG2, `FEAT_WIN_LOG2 (3): log2 of averaging window depth (8 samples); legal range 1..6.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of window, peak, brake history
- in_valid  in  1  input sample qualifier
- in_accel  in  DATA_WIDTH  signed two's-complement acceleration
- in_brake  in  DATA_WIDTH  unsigned brake pedal position
- feat_accel_mag  out  DATA_WIDTH  unsigned windowed mean of abs(accel)
- feat_accel_peak  out  DATA_WIDTH  unsigned max abs(accel) since reset/clear
- feat_brake_rate  out  DATA_WIDTH  signed brake delta, saturated
- data_valid  out  1  one-cycle pulse per accepted sample once window full
- window_full  out  1  level; window holds 2^WIN_LOG2 samples

Behaviour:
- Reset (rst_n=0, async): all outputs 0. Window buffer, running sum, fill counter, write pointer, brake history and the history-valid flag are all 0.
- Stage 1 (cycle N, in_valid=1):
  - mag = abs(in_accel). The most negative input maps to 2^(DATA_WIDTH-1)-1.
  - delta = in_brake − prev_brake, computed at DATA_WIDTH+1 bits and saturated to the signed DATA_WIDTH range.
  - If the history-valid flag is 0, delta = 0.
  - prev_brake <= in_brake and the history-valid flag <= 1.
  - Register mag, delta and a stage-1 valid bit.
- Stage 2 (cycle N+1):
  - Circular buffer of 2^WIN_LOG2 entries.
  - sum_next = sum + mag − buf[wptr]; the sum is DATA_WIDTH+WIN_LOG2 bits wide and never overflows.
  - buf[wptr] <= mag; wptr increments and wraps modulo depth.
  - The fill counter saturates at depth. window_full is set when the counter reaches depth.
- Outputs (registered, visible at N+2):
  - feat_accel_mag <= sum_next >> WIN_LOG2 (truncating).
  - feat_accel_peak <= max(peak, mag).
  - feat_brake_rate <= delta.
  - data_valid = 1 for one cycle only if the fill count including this sample equals depth.
- Warm-up: mag, peak and rate update on every accepted sample. data_valid stays 0 until the depth-th sample after reset/clear.
- Outputs hold their values when in_valid=0. Back-to-back in_valid gives one result per cycle with fully pipelined throughput.
- clear=1:
  - Next edge zeroes buffer, sum, counter, wptr, peak, history flag, window_full and pipeline valid bits.
  - feat_accel_mag and feat_brake_rate hold their last value; data_valid=0.
  - Samples in flight are discarded.
- clear and in_valid on the same cycle: clear wins and the sample is dropped.
- Reset mid-operation: immediate return to the reset state; no partial result emerges.

Decomposition:
- safety_params.vh adds `FEAT_WIN_LOG2 and abs/saturation width constants.
- Sub-module feat_window_avg holds the circular buffer, running sum, fill counter and window_full. Parameters are DATA_WIDTH and WIN_LOG2. Ports are clk, rst_n, clear, valid and mag, with avg and full outputs.
- Top-level feature_extractor_win holds stage 1, peak, brake rate and output registers.

Test Plan:
- Reset, then idle: all outputs 0; data_valid never asserts with in_valid=0.
- Eight back-to-back samples, accel=100 and brake=500:
  - Samples 1..7 give data_valid=0.
  - Sample 8 gives data_valid=1 at 2 cycles latency, mag=100, peak=100, window_full=1.
  - First rate=0, subsequent rates=0.
- After that full window, four samples of accel=−300: mag=200 after the fourth sample, peak=300.
- accel=0x8000 gives mag contribution and peak 0x7FFF.
- brake 1000→400 gives rate=−600 (0xFDA8). Brake 0→0xFFFF gives rate=0x7FFF, and 0xFFFF→0 gives rate=0x8000.
- clear asserted with in_valid while warm:
  - The sample is dropped and window_full=0, peak=0.
  - Eight new samples are required before data_valid.
  - The first post-clear rate=0.
  - in_valid gaps between samples do not alter outputs.

Source files
------------

// File: rtl/feature_extractor_win_pkg.sv
// Shared constants for the windowed feature extractor.
package feature_extractor_win_pkg;

   // Default sample/feature width.
   localparam int unsigned FEAT_DATA_WIDTH = 16;

   // log2 of the averaging window depth (8 samples); legal range 1..6.
   localparam int unsigned FEAT_WIN_LOG2     = 3;
   localparam int unsigned FEAT_WIN_LOG2_MIN = 1;
   localparam int unsigned FEAT_WIN_LOG2_MAX = 6;

   // Extra bit carried by the brake delta before saturation back to DATA_WIDTH.
   localparam int unsigned FEAT_DELTA_EXTRA = 1;

endpackage

// File: rtl/feature_extractor_win_avg.sv
// Circular-buffer moving average of accel magnitude with fill tracking.
// avg and full are combinational views of the state *including* the sample
// currently presented on valid/mag, so the parent can register them alongside
// the other features in the same cycle.
module feat_window_avg
   import feature_extractor_win_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FEAT_DATA_WIDTH,
   parameter int unsigned WIN_LOG2   = FEAT_WIN_LOG2
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] mag,
   output logic [DATA_WIDTH-1:0] avg,
   output logic                  full
);

   localparam int unsigned DEPTH = 1 << WIN_LOG2;
   localparam int unsigned SUM_W = DATA_WIDTH + WIN_LOG2;
   localparam logic [WIN_LOG2:0] DEPTH_CNT = (WIN_LOG2 + 1)'(DEPTH);
   localparam logic [WIN_LOG2:0] CNT_ONE   = (WIN_LOG2 + 1)'(1);
   localparam logic [WIN_LOG2-1:0] PTR_ONE = WIN_LOG2'(1);

   logic [DATA_WIDTH-1:0] win_buf [DEPTH];
   logic [SUM_W-1:0]      sum;
   logic [SUM_W-1:0]      sum_next;
   logic [WIN_LOG2-1:0]   wptr;
   logic [WIN_LOG2:0]     count;
   logic [WIN_LOG2:0]     count_next;

   // Next running sum and saturating fill count for the presented sample.
   always_comb begin
      sum_next   = sum;
      count_next = count;
      if (valid) begin
         sum_next   = sum + SUM_W'(mag) - SUM_W'(win_buf[wptr]);
         count_next = (count == DEPTH_CNT) ? count : count + CNT_ONE;
      end
   end

   assign avg  = DATA_WIDTH'(sum_next >> WIN_LOG2);
   assign full = (count_next == DEPTH_CNT);

   // Window state: cleared by reset or clear, advanced on each valid sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) win_buf[i] <= '0;
         sum   <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (clear) begin
         for (int unsigned i = 0; i < DEPTH; i++) win_buf[i] <= '0;
         sum   <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (valid) begin
         win_buf[wptr] <= mag;
         sum           <= sum_next;
         wptr          <= wptr + PTR_ONE;
         count         <= count_next;
      end
   end

endmodule

// File: rtl/feature_extractor_win.sv
// Windowed feature extractor: accel magnitude mean, accel peak and saturated
// brake rate. Two-cycle pipeline: stage 1 abs/delta, stage 2 window update,
// then registered outputs.
module feature_extractor_win
   import feature_extractor_win_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FEAT_DATA_WIDTH,
   parameter int unsigned WIN_LOG2   = FEAT_WIN_LOG2
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_accel,
   input  logic [DATA_WIDTH-1:0] in_brake,
   output logic [DATA_WIDTH-1:0] feat_accel_mag,
   output logic [DATA_WIDTH-1:0] feat_accel_peak,
   output logic [DATA_WIDTH-1:0] feat_brake_rate,
   output logic                  data_valid,
   output logic                  window_full
);

   localparam int unsigned DELTA_W = DATA_WIDTH + FEAT_DELTA_EXTRA;
   localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] NEG_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [DATA_WIDTH-1:0] mag_in;
   logic [DELTA_W-1:0]    diff;
   logic [DATA_WIDTH-1:0] delta_sat;

   logic                  hist_valid;
   logic [DATA_WIDTH-1:0] prev_brake;
   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_mag;
   logic [DATA_WIDTH-1:0] s1_delta;

   logic [DATA_WIDTH-1:0] win_avg;
   logic                  win_full;

   // abs(accel), with the most negative code clamped to the positive maximum.
   always_comb begin
      mag_in = in_accel;
      if (in_accel == NEG_MIN)
         mag_in = POS_MAX;
      else if (in_accel[DATA_WIDTH-1])
         mag_in = -in_accel;
   end

   // Brake delta at one extra bit, saturated back to signed DATA_WIDTH.
   always_comb begin
      diff      = {1'b0, in_brake} - {1'b0, prev_brake};
      delta_sat = diff[DATA_WIDTH-1:0];
      if (diff[DELTA_W-1] != diff[DATA_WIDTH-1])
         delta_sat = diff[DELTA_W-1] ? NEG_MIN : POS_MAX;
   end

   // Stage 1: capture magnitude and delta; clear drops the incoming sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_mag     <= '0;
         s1_delta   <= '0;
         prev_brake <= '0;
         hist_valid <= 1'b0;
      end else if (clear) begin
         s1_valid   <= 1'b0;
         prev_brake <= '0;
         hist_valid <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_mag     <= mag_in;
            s1_delta   <= hist_valid ? delta_sat : '0;
            prev_brake <= in_brake;
            hist_valid <= 1'b1;
         end
      end
   end

   feat_window_avg #(
      .DATA_WIDTH (DATA_WIDTH),
      .WIN_LOG2   (WIN_LOG2)
   ) u_window (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .valid (s1_valid),
      .mag   (s1_mag),
      .avg   (win_avg),
      .full  (win_full)
   );

   // Output registers; mag and rate hold across clear, peak and full do not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         feat_accel_mag  <= '0;
         feat_accel_peak <= '0;
         feat_brake_rate <= '0;
         data_valid      <= 1'b0;
         window_full     <= 1'b0;
      end else if (clear) begin
         feat_accel_peak <= '0;
         data_valid      <= 1'b0;
         window_full     <= 1'b0;
      end else begin
         window_full <= win_full;
         data_valid  <= s1_valid & win_full;
         if (s1_valid) begin
            feat_accel_mag  <= win_avg;
            feat_brake_rate <= s1_delta;
            if (s1_mag > feat_accel_peak)
               feat_accel_peak <= s1_mag;
         end
      end
   end

endmodule

// File: tb/tb_feature_extractor_win.sv
// Scoreboard bench for feature_extractor_win: a behavioural model queues the
// expected outputs per accepted sample; a monitor pops and compares them when
// they fall due and otherwise checks that outputs hold and data_valid is low.
module tb_feature_extractor_win;

   localparam int DW    = 16;
   localparam int WL    = 3;
   localparam int DEPTH = 1 << WL;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_accel = '0;
   logic [DW-1:0] in_brake = '0;
   logic [DW-1:0] feat_accel_mag;
   logic [DW-1:0] feat_accel_peak;
   logic [DW-1:0] feat_brake_rate;
   logic          data_valid;
   logic          window_full;

   feature_extractor_win #(
      .DATA_WIDTH (DW),
      .WIN_LOG2   (WL)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear           (clear),
      .in_valid        (in_valid),
      .in_accel        (in_accel),
      .in_brake        (in_brake),
      .feat_accel_mag  (feat_accel_mag),
      .feat_accel_peak (feat_accel_peak),
      .feat_brake_rate (feat_brake_rate),
      .data_valid      (data_valid),
      .window_full     (window_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned   due;
      logic          dv;
      logic [DW-1:0] mag;
      logic [DW-1:0] peak;
      logic [DW-1:0] rate;
      logic          full;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        hold;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   bit          mon_en = 1'b0;

   // model state
   int m_win[DEPTH];
   int m_wp, m_cnt, m_peak, m_prev;
   bit m_hist;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_win[i] = 0;
      m_wp = 0; m_cnt = 0; m_peak = 0; m_prev = 0; m_hist = 1'b0;
   endtask

   task automatic model_push(input logic [DW-1:0] a, input logic [DW-1:0] b);
      exp_t e;
      int sa, mg, sum, d;
      sa = int'($signed(a));
      mg = (sa < 0) ? -sa : sa;
      if (mg > 32767) mg = 32767;
      m_win[m_wp] = mg;
      m_wp = (m_wp + 1) % DEPTH;
      if (m_cnt < DEPTH) m_cnt++;
      sum = 0;
      for (int i = 0; i < DEPTH; i++) sum += m_win[i];
      if (mg > m_peak) m_peak = mg;
      d = 0;
      if (m_hist) begin
         d = int'(b) - m_prev;
         if (d > 32767) d = 32767;
         if (d < -32768) d = -32768;
      end
      m_prev = int'(b);
      m_hist = 1'b1;
      e.due  = cyc + 2;
      e.full = (m_cnt == DEPTH);
      e.dv   = e.full;
      e.mag  = DW'(sum / DEPTH);
      e.peak = DW'(m_peak);
      e.rate = DW'(d);
      sb_q.push_back(e);
   endtask

   // Present one sample (or a clear with a sample) for one cycle.
   task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic clr);
      @(negedge clk);
      in_valid = 1'b1; in_accel = a; in_brake = b; clear = clr;
      if (clr) begin
         model_reset();
         hold.peak = '0;
         hold.full = 1'b0;
      end else begin
         model_push(a, b);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0; clear = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      check_eq("drain", sb_q.size(), 0);
   endtask

   // Monitor: 2 time units after each rising edge.
   always begin
      exp_t e;
      @(posedge clk);
      cyc++;
      #2;
      if (rst_n && mon_en) begin
         if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check_eq("dv",   data_valid,      e.dv);
            check_eq("mag",  feat_accel_mag,  e.mag);
            check_eq("peak", feat_accel_peak, e.peak);
            check_eq("rate", feat_brake_rate, e.rate);
            check_eq("full", window_full,     e.full);
            hold = e;
         end else begin
            check_eq("dv_idle",   data_valid,      1'b0);
            check_eq("hold_mag",  feat_accel_mag,  hold.mag);
            check_eq("hold_peak", feat_accel_peak, hold.peak);
            check_eq("hold_rate", feat_brake_rate, hold.rate);
            check_eq("hold_full", window_full,     hold.full);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      hold = '{due: 0, dv: 1'b0, mag: '0, peak: '0, rate: '0, full: 1'b0};
      model_reset();

      // reset state
      repeat (3) @(negedge clk);
      check_eq("rst_mag",  feat_accel_mag,  '0);
      check_eq("rst_peak", feat_accel_peak, '0);
      check_eq("rst_rate", feat_brake_rate, '0);
      check_eq("rst_dv",   data_valid,      '0);
      check_eq("rst_full", window_full,     '0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      idle(4);

      // warm-up: eight constant samples
      for (int i = 0; i < DEPTH; i++) drive(16'd100, 16'd500, 1'b0);
      idle(1); drain();
      check_eq("warm_mag",  feat_accel_mag,  16'd100);
      check_eq("warm_peak", feat_accel_peak, 16'd100);
      check_eq("warm_full", window_full,     1'b1);
      check_eq("warm_rate", feat_brake_rate, 16'd0);

      // four samples of -300
      for (int i = 0; i < 4; i++) drive(16'hFED4, 16'd500, 1'b0);
      idle(1); drain();
      check_eq("neg_mag",  feat_accel_mag,  16'd200);
      check_eq("neg_peak", feat_accel_peak, 16'd300);

      // most negative accel, brake decrease with a gap in between
      drive(16'h8000, 16'd1000, 1'b0);
      idle(2);
      drive(16'd10, 16'd400, 1'b0);
      idle(1); drain();
      check_eq("minneg_peak", feat_accel_peak, 16'h7FFF);
      check_eq("rate_m600",   feat_brake_rate, 16'hFDA8);

      // brake saturation both ways
      drive(16'd0, 16'h0000, 1'b0);
      drive(16'd0, 16'hFFFF, 1'b0);
      idle(1); drain();
      check_eq("rate_satpos", feat_brake_rate, 16'h7FFF);
      drive(16'd0, 16'h0000, 1'b0);
      idle(1); drain();
      check_eq("rate_satneg", feat_brake_rate, 16'h8000);

      // clear together with a sample while warm
      idle(2);
      drive(16'd5000, 16'd123, 1'b1);
      idle(1);
      check_eq("clr_full", window_full,     1'b0);
      check_eq("clr_peak", feat_accel_peak, 16'd0);
      check_eq("clr_dv",   data_valid,      1'b0);
      check_eq("clr_rate_hold", feat_brake_rate, 16'h8000);

      // re-warm with random gaps
      for (int i = 0; i < DEPTH; i++) begin
         drive(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0);
         idle($urandom_range(0, 3));
      end
      idle(1); drain();
      check_eq("rewarm_full", window_full, 1'b1);

      // back-to-back random stream with occasional extreme accel
      for (int i = 0; i < 24; i++) begin
         if (i % 7 == 3) drive(16'h8000, 16'($urandom_range(0, 65535)), 1'b0);
         else drive(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0);
      end
      idle(1); drain();

      // reset mid-operation: in-flight sample must not emerge
      drive(16'd1234, 16'd777, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check_eq("mid_rst_mag",  feat_accel_mag,  '0);
      check_eq("mid_rst_peak", feat_accel_peak, '0);
      check_eq("mid_rst_rate", feat_brake_rate, '0);
      check_eq("mid_rst_dv",   data_valid,      '0);
      check_eq("mid_rst_full", window_full,     '0);
      repeat (2) @(negedge clk);
      model_reset();
      hold = '{due: 0, dv: 1'b0, mag: '0, peak: '0, rate: '0, full: 1'b0};
      rst_n = 1'b1;
      idle(4);

      // first post-reset sample: rate 0, partial window
      drive(16'd80, 16'd999, 1'b0);
      idle(1); drain();
      check_eq("post_rst_rate", feat_brake_rate, 16'd0);
      check_eq("post_rst_mag",  feat_accel_mag,  16'd10);

      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
